// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART buffer definitions (data width, buffer FSM states)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Presentation FSM shared by the tx- and rx-side buffers
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } uart_buf_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Generic circular-buffer FIFO with push/pop/flush and a
//               separate level counter. Read data is mem[rd_ptr] (show-ahead).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [LVL_W-1:0] c_LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  // Flush wins over everything; a push only lands when there is room
  assign w_push = push_i & ~full_o  & ~flush_i;
  assign w_pop  = pop_i  & ~empty_o & ~flush_i;

  assign pop_data_o = r_mem[r_rd_ptr];
  assign level_o    = r_level;
  assign empty_o    = (r_level == '0);
  assign full_o     = (r_level == c_LVL_FULL);

  // Storage array: no reset needed, contents are only read when level > 0
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Level counter: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_level <= '0;
    end else if (flush_i) begin
      r_level <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit buffer in front of the UART transmitter. Bytes are
//               queued through a valid/ready port, popped into a holding
//               register and held stable on tx_data_o/tx_valid_o for a whole
//               frame, then retired on the transmitter's tx_done_i pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = UART_DATA_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_done_i,
  output logic [LVL_W-1:0]  level_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              busy_o,
  output logic              overflow_o
);

  uart_buf_state_e   r_state;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_overflow;

  logic [DATA_W-1:0] w_pop_data;
  logic [LVL_W-1:0]  w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  // Ready comes from the registered full flag only, never from this cycle's pop
  assign wr_ready_o = ~w_full;
  assign w_push     = wr_valid_i & ~w_full & ~flush_i;

  // Load the holding register when idle, or back-to-back when a frame ends
  assign w_pop = ~flush_i & ~w_empty &
                 ((r_state == IDLE) | ((r_state == SEND) & tx_done_i));

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .flush_i     (flush_i),
    .push_i      (w_push),
    .push_data_i (wr_data_i),
    .pop_i       (w_pop),
    .pop_data_o  (w_pop_data),
    .level_o     (w_level),
    .empty_o     (w_empty),
    .full_o      (w_full)
  );

  // Presentation FSM with registered tx_valid/tx_data (holding register)
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (flush_i) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_pop_data;
            r_tx_valid <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_pop) begin
            r_tx_data <= w_pop_data;
          end else if (tx_done_i) begin
            r_tx_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a write attempted while full; cleared only by flush/reset
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_overflow <= 1'b0;
    end else if (wr_valid_i & w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign busy_o     = r_tx_valid;
  assign overflow_o = r_overflow;
  assign level_o    = w_level;
  assign empty_o    = w_empty;
  assign full_o     = w_full;

endmodule : uart_tx_fifo
`default_nettype wire
